// File: rtl/cpu32e_exc_pkg.sv
// Shared types and helpers for the exception controller and the control unit.
package cpu32e_exc_pkg;

  // Widest configuration the controller supports; helpers are sized to it.
  localparam int EXC_MAX_NUM     = 64;
  localparam int EXC_MAX_IDX_W   = 6;
  localparam int EXC_DEFAULT_NUM = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } exc_state_t;

  // One-hot vector of the given index, used to clear the accepted pending bit.
  function automatic logic [EXC_MAX_NUM-1:0] onehot_clear(input logic [EXC_MAX_IDX_W-1:0] idx);
    logic [EXC_MAX_NUM-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/exception_priority_encoder.sv
// Fixed-priority encoder: the lowest set request index wins.
module exception_priority_encoder #(
  parameter int NUM_EXC = 16,
  parameter int IDX_W   = $clog2(NUM_EXC)
) (
  input  logic [NUM_EXC-1:0] i_req,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any_valid
);

  // Scan from the top down so the lowest set bit is the last to be written.
  always_comb begin
    o_index = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_index = IDX_W'(i);
      end
    end
  end

  assign o_any_valid = |i_req;

endmodule

// File: rtl/exception_controller.sv
// Sticky-pending, maskable exception controller with a valid/ack/return handshake.
module exception_controller
  import cpu32e_exc_pkg::*;
#(
  parameter int                 NUM_EXC    = 16,
  parameter int                 IDX_W      = $clog2(NUM_EXC),
  parameter logic [NUM_EXC-1:0] NMI_MASK   = {NUM_EXC{1'b0}},
  parameter logic [NUM_EXC-1:0] MASK_RESET = {NUM_EXC{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_EXC-1:0] i_exc_trigger,
  input  logic               i_mask_we,
  input  logic [NUM_EXC-1:0] i_mask_wdata,
  output logic [NUM_EXC-1:0] o_mask_q,
  output logic [NUM_EXC-1:0] o_pending_q,
  output logic               o_exc_valid,
  output logic [IDX_W-1:0]   o_exc_index,
  input  logic               i_exc_ack,
  input  logic               i_exc_return,
  output logic               o_in_service
);

  exc_state_t           r_state;
  logic [NUM_EXC-1:0]   r_pending;
  logic [NUM_EXC-1:0]   r_mask;
  logic                 r_exc_valid;
  logic [IDX_W-1:0]     r_exc_index;
  logic                 r_in_service;

  logic [NUM_EXC-1:0]     w_eligible;
  logic [IDX_W-1:0]       w_win_index;
  logic                   w_any_eligible;
  logic                   w_ack_taken;
  logic [EXC_MAX_NUM-1:0] w_clr_full;
  logic [NUM_EXC-1:0]     w_clr;

  // Non-maskable sources see an always-enabled mask bit.
  assign w_eligible = r_pending & (r_mask | NMI_MASK);

  exception_priority_encoder #(
    .NUM_EXC (NUM_EXC),
    .IDX_W   (IDX_W)
  ) u_prio (
    .i_req       (w_eligible),
    .o_index     (w_win_index),
    .o_any_valid (w_any_eligible)
  );

  // Only an ack seen while presenting clears the presented bit.
  assign w_ack_taken = (r_state == REQUEST) && i_exc_ack;
  assign w_clr_full  = w_ack_taken ? onehot_clear(EXC_MAX_IDX_W'(r_exc_index)) : '0;
  assign w_clr       = w_clr_full[NUM_EXC-1:0];

  // Sticky pending bits; a trigger in the clearing cycle keeps the bit set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | i_exc_trigger;
    end
  end

  // Mask register; the presented request is held by the FSM, so a write cannot withdraw it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= MASK_RESET;
    end else if (i_mask_we) begin
      r_mask <= i_mask_wdata;
    end
  end

  // Presentation FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_exc_valid  <= 1'b0;
      r_exc_index  <= '0;
      r_in_service <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_eligible) begin
            r_state     <= REQUEST;
            r_exc_valid <= 1'b1;
            r_exc_index <= w_win_index;
          end
        end
        REQUEST: begin
          // Ack takes precedence over a simultaneous return.
          if (i_exc_ack) begin
            r_state      <= SERVICE;
            r_exc_valid  <= 1'b0;
            r_in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (i_exc_return) begin
            r_state      <= IDLE;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_exc_valid  <= 1'b0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign o_mask_q     = r_mask;
  assign o_pending_q  = r_pending;
  assign o_exc_valid  = r_exc_valid;
  assign o_exc_index  = r_exc_index;
  assign o_in_service = r_in_service;

endmodule

// File: tb/tb_exception_controller.sv
// Directed testbench for exception_controller (16 sources, source 0 non-maskable).
module tb_exception_controller;

  localparam int NUM_EXC = 16;
  localparam int IDX_W   = 4;

  logic               clk;
  logic               rst_n;
  logic [NUM_EXC-1:0] exc_trigger;
  logic               mask_we;
  logic [NUM_EXC-1:0] mask_wdata;
  logic [NUM_EXC-1:0] mask_q;
  logic [NUM_EXC-1:0] pending_q;
  logic               exc_valid;
  logic [IDX_W-1:0]   exc_index;
  logic               exc_ack;
  logic               exc_return;
  logic               in_service;

  int n_checks;
  int n_errors;

  exception_controller #(
    .NUM_EXC    (NUM_EXC),
    .IDX_W      (IDX_W),
    .NMI_MASK   (16'h0001),
    .MASK_RESET (16'hFFFF)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_exc_trigger (exc_trigger),
    .i_mask_we     (mask_we),
    .i_mask_wdata  (mask_wdata),
    .o_mask_q      (mask_q),
    .o_pending_q   (pending_q),
    .o_exc_valid   (exc_valid),
    .o_exc_index   (exc_index),
    .i_exc_ack     (exc_ack),
    .i_exc_return  (exc_return),
    .o_in_service  (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input logic [NUM_EXC-1:0] v);
    exc_trigger = v;
    tick();
    exc_trigger = '0;
  endtask

  task automatic write_mask(input logic [NUM_EXC-1:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic ack_and_return();
    exc_ack = 1'b1;
    tick();
    exc_ack    = 1'b0;
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    exc_trigger = '0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    exc_ack     = 1'b0;
    exc_return  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check_value("rst_pending", 64'(pending_q), 64'h0);
    check_value("rst_mask", 64'(mask_q), 64'hFFFF);
    check_value("rst_valid", 64'(exc_valid), 64'h0);
    check_value("rst_index", 64'(exc_index), 64'h0);
    check_value("rst_in_service", 64'(in_service), 64'h0);

    // Single pulse on source 3: pending next cycle, valid the cycle after
    pulse_trigger(16'h0008);
    check_value("t1_pending", 64'(pending_q), 64'h0008);
    check_value("t1_valid_early", 64'(exc_valid), 64'h0);
    tick();
    check_value("t1_valid", 64'(exc_valid), 64'h1);
    check_value("t1_index", 64'(exc_index), 64'h3);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check_value("t1_pending_ack", 64'(pending_q), 64'h0);
    check_value("t1_in_service", 64'(in_service), 64'h1);
    check_value("t1_valid_drop", 64'(exc_valid), 64'h0);
    // Ack outside REQUEST is ignored
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check_value("t1_ack_ignored", 64'(in_service), 64'h1);
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    check_value("t1_returned", 64'(in_service), 64'h0);
    tick();
    check_value("t1_idle_valid", 64'(exc_valid), 64'h0);

    // Two sources: lowest index first, then the other after return
    exc_trigger = 16'h8010;
    tick();
    tick();
    exc_trigger = '0;
    check_value("t2_first_index", 64'(exc_index), 64'h4);
    check_value("t2_first_valid", 64'(exc_valid), 64'h1);
    ack_and_return();
    tick();
    check_value("t2_second_valid", 64'(exc_valid), 64'h1);
    check_value("t2_second_index", 64'(exc_index), 64'hF);
    check_value("t2_second_pending", 64'(pending_q), 64'h8000);
    ack_and_return();

    // Non-maskable source 0 bypasses a cleared mask bit
    write_mask(16'hFFFE);
    check_value("t3_mask", 64'(mask_q), 64'hFFFE);
    pulse_trigger(16'h0003);
    tick();
    check_value("t3_nmi_index", 64'(exc_index), 64'h0);
    check_value("t3_nmi_valid", 64'(exc_valid), 64'h1);
    ack_and_return();
    tick();
    check_value("t3_src1_index", 64'(exc_index), 64'h1);
    ack_and_return();
    // Masked source stays pending, presented once unmasked
    write_mask(16'hFFFD);
    pulse_trigger(16'h0002);
    tick();
    tick();
    check_value("t3_masked_valid", 64'(exc_valid), 64'h0);
    check_value("t3_masked_pending", 64'(pending_q), 64'h0002);
    write_mask(16'hFFFF);
    tick();
    check_value("t3_unmasked_valid", 64'(exc_valid), 64'h1);
    check_value("t3_unmasked_index", 64'(exc_index), 64'h1);
    ack_and_return();

    // No preemption by a higher-priority source while presenting
    pulse_trigger(16'h0004);
    tick();
    check_value("t4_index", 64'(exc_index), 64'h2);
    pulse_trigger(16'h0001);
    check_value("t4_hold_index", 64'(exc_index), 64'h2);
    check_value("t4_pending", 64'(pending_q), 64'h0005);
    tick();
    check_value("t4_hold_index2", 64'(exc_index), 64'h2);
    ack_and_return();
    tick();
    check_value("t4_next_index", 64'(exc_index), 64'h0);
    check_value("t4_next_valid", 64'(exc_valid), 64'h1);
    ack_and_return();

    // Re-trigger in the ack cycle keeps the bit pending
    pulse_trigger(16'h0020);
    tick();
    check_value("t5_index", 64'(exc_index), 64'h5);
    exc_ack     = 1'b1;
    exc_trigger = 16'h0020;
    tick();
    exc_ack     = 1'b0;
    exc_trigger = '0;
    check_value("t5_pending_kept", 64'(pending_q), 64'h0020);
    check_value("t5_in_service", 64'(in_service), 64'h1);
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;
    tick();
    check_value("t5_represent_valid", 64'(exc_valid), 64'h1);
    check_value("t5_represent_index", 64'(exc_index), 64'h5);
    // Ack and return together in REQUEST: only ack honoured
    exc_ack    = 1'b1;
    exc_return = 1'b1;
    tick();
    exc_ack    = 1'b0;
    exc_return = 1'b0;
    check_value("t5_ackret_service", 64'(in_service), 64'h1);
    check_value("t5_ackret_valid", 64'(exc_valid), 64'h0);
    exc_return = 1'b1;
    tick();
    exc_return = 1'b0;

    // Asynchronous reset while in SERVICE with pending bits
    pulse_trigger(16'h0100);
    tick();
    check_value("t6_index", 64'(exc_index), 64'h8);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    pulse_trigger(16'h0F00);
    write_mask(16'h0000);
    check_value("t6_pending_pre", 64'(pending_q), 64'h0F00);
    check_value("t6_service_pre", 64'(in_service), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("t6_rst_pending", 64'(pending_q), 64'h0);
    check_value("t6_rst_mask", 64'(mask_q), 64'hFFFF);
    check_value("t6_rst_service", 64'(in_service), 64'h0);
    check_value("t6_rst_valid", 64'(exc_valid), 64'h0);
    check_value("t6_rst_index", 64'(exc_index), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check_value("t6_post_valid", 64'(exc_valid), 64'h0);
    check_value("t6_post_pending", 64'(pending_q), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
